// File: rtl/apb_pixel_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module  : apb_pixel_regfile_pkg
// Purpose : Shared constants for the APB pixel register file: default bus
//           geometry, register map, CTRL/STATUS bit positions and the
//           transfer FSM state encodings.
// Ports   : none (package)
// Config  : none here; the top level honours APB_PSTRB_EN.
// Revision: 1.0 - initial release
// ============================================================================
package apb_pixel_regfile_pkg;

    // Default bus geometry
    localparam int c_amba_word_default       = 24;
    localparam int c_amba_addr_depth_default = 12;

    // Word-address register map; everything from c_pix_base upward is the
    // pixel bank.
    localparam int c_reg_ctrl   = 0;
    localparam int c_reg_status = 1;
    localparam int c_reg_result = 2;
    localparam int c_pix_base   = 3;

    // Register bit positions
    localparam int c_ctrl_start_bit  = 0;
    localparam int c_status_busy_bit = 0;
    localparam int c_status_done_bit = 1;

    // Transfer FSM.
    //   c_st_idle    : no transfer in flight; the bus SETUP cycle is observed
    //                  here and the request is latched.
    //   c_st_access  : first ACCESS cycle; writes complete here, reads launch
    //                  the synchronous RAM read.
    //   c_st_rd_wait : second ACCESS cycle of a read; read data is returned.
    typedef logic [1:0] state_t;
    localparam state_t c_st_idle    = 2'd0;
    localparam state_t c_st_access  = 2'd1;
    localparam state_t c_st_rd_wait = 2'd2;

endpackage
`default_nettype wire

// File: rtl/apb_pixel_regfile_pixel_ram_dp.sv
`default_nettype none
// ============================================================================
// Module  : pixel_ram_dp
// Purpose : Pixel bank storage. Port A is the APB write/read port with byte
//           enables; port B is the core's read-only port. Both reads are
//           synchronous (one cycle latency). Contents are not reset.
// Ports   : clk        - clock, rising edge
//           i_a_addr   - port A word address
//           i_a_be     - port A byte enables (all zero = no write)
//           i_a_wdata  - port A write data
//           o_a_rdata  - port A read data, registered
//           i_b_addr   - port B word address
//           o_b_rdata  - port B read data, registered
// Revision: 1.0 - initial release
// ============================================================================
module pixel_ram_dp #(
    parameter int WIDTH      = 24,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                    clk,
    input  logic [DEPTH_LOG2-1:0]   i_a_addr,
    input  logic [WIDTH/8-1:0]      i_a_be,
    input  logic [WIDTH-1:0]        i_a_wdata,
    output logic [WIDTH-1:0]        o_a_rdata,
    input  logic [DEPTH_LOG2-1:0]   i_b_addr,
    output logic [WIDTH-1:0]        o_b_rdata
);

    localparam int c_lanes = WIDTH / 8;
    localparam int c_depth = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] r_mem [0:c_depth-1];
    logic [WIDTH-1:0] r_a_rdata;
    logic [WIDTH-1:0] r_b_rdata;

    // Reads use the pre-edge contents, so a port B read of the address being
    // written in the same cycle returns the old word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < c_lanes; i++) begin
            if (i_a_be[i]) begin
                r_mem[i_a_addr][8*i +: 8] <= i_a_wdata[8*i +: 8];
            end
        end
        r_a_rdata <= r_mem[i_a_addr];
        r_b_rdata <= r_mem[i_b_addr];
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule
`default_nettype wire

// File: rtl/apb_pixel_regfile.sv
`default_nettype none
// ============================================================================
// Module  : apb_pixel_regfile
// Purpose : APB3 slave register file for the cat-recognizer datapath.
//           CTRL (self-clearing START), STATUS (BUSY, sticky W1C DONE),
//           RESULT (read-only) and a pixel bank read by the core on a
//           private port. Writes complete with zero wait states, reads with
//           one wait state. PSLVERR flags dropped writes.
// Ports   : clock, reset(async, active-low)
//           psel, penable, pwrite, paddr, pwdata, [pstrb]  - APB request
//           prdata, pready, pslverr                        - APB response
//           start                                          - start pulse
//           core_busy, core_done, core_result              - core status
//           core_raddr, core_rdata                         - core pixel port
// Config  : APB_PSTRB_EN - adds the pstrb port; only strobed byte lanes are
//           written (CTRL and pixel bank); pstrb==0 is an error-free no-op.
//           Undefined: every write updates the full word.
// Revision: 1.0 - initial release
// ============================================================================
module apb_pixel_regfile
    import apb_pixel_regfile_pkg::*;
#(
    parameter int AMBA_WORD       = c_amba_word_default,
    parameter int AMBA_ADDR_DEPTH = c_amba_addr_depth_default
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        psel,
    input  logic                        penable,
    input  logic                        pwrite,
    input  logic [AMBA_ADDR_DEPTH-1:0]  paddr,
    input  logic [AMBA_WORD-1:0]        pwdata,
`ifdef APB_PSTRB_EN
    input  logic [AMBA_WORD/8-1:0]      pstrb,
`endif
    output logic [AMBA_WORD-1:0]        prdata,
    output logic                        pready,
    output logic                        pslverr,
    output logic                        start,
    input  logic                        core_busy,
    input  logic                        core_done,
    input  logic [AMBA_WORD-1:0]        core_result,
    input  logic [AMBA_ADDR_DEPTH-1:0]  core_raddr,
    output logic [AMBA_WORD-1:0]        core_rdata
);

    localparam int c_lanes = AMBA_WORD / 8;

    localparam logic [AMBA_ADDR_DEPTH-1:0] c_addr_ctrl   = AMBA_ADDR_DEPTH'(c_reg_ctrl);
    localparam logic [AMBA_ADDR_DEPTH-1:0] c_addr_status = AMBA_ADDR_DEPTH'(c_reg_status);
    localparam logic [AMBA_ADDR_DEPTH-1:0] c_addr_result = AMBA_ADDR_DEPTH'(c_reg_result);
    localparam logic [AMBA_ADDR_DEPTH-1:0] c_addr_pix    = AMBA_ADDR_DEPTH'(c_pix_base);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t                         r_state;
    state_t                         w_next_state;

    logic                           r_write;
    logic [AMBA_ADDR_DEPTH-1:0]     r_addr;
    logic                           r_done;
    logic [AMBA_WORD-1:0]           r_result;
    logic                           r_start;
    logic [AMBA_WORD-1:0]           r_reg_rdata;
    logic                           r_rd_pix;
    logic                           r_core_zero;

    logic                           w_setup;
    logic                           w_wr_cyc;
    logic                           w_rd_cyc;
    logic                           w_pready;
    logic                           w_rd_done;

    logic [c_lanes-1:0]             w_strb;
    logic                           w_any_strb;
    logic                           w_is_ctrl;
    logic                           w_is_status;
    logic                           w_is_result;
    logic                           w_is_pix;
    logic                           w_start_bit;
    logic                           w_clr_bit;
    logic                           w_err;
    logic                           w_start_req;
    logic                           w_clr_done;
    logic [c_lanes-1:0]             w_ram_be;
    logic [AMBA_WORD-1:0]           w_reg_rdata_next;
    logic [AMBA_WORD-1:0]           w_ram_a_rdata;
    logic [AMBA_WORD-1:0]           w_ram_b_rdata;

    // ------------------------------------------------------------------
    // Byte strobes
    // ------------------------------------------------------------------
`ifdef APB_PSTRB_EN
    assign w_strb = pstrb;
`else
    assign w_strb = '1;
`endif

    // ------------------------------------------------------------------
    // Transfer FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM: next state. A completed transfer always returns to
    // idle, which is also where the SETUP cycle of a back-to-back transfer
    // is caught, so no idle bus cycle is required between transfers.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (psel && !penable) begin
                    w_next_state = c_st_access;
                end
            end
            c_st_access: begin
                w_next_state = r_write ? c_st_idle : c_st_rd_wait;
            end
            c_st_rd_wait: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transfer FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_setup   = 1'b0;
        w_wr_cyc  = 1'b0;
        w_rd_cyc  = 1'b0;
        w_pready  = 1'b0;
        w_rd_done = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_setup = psel && !penable;
            end
            c_st_access: begin
                w_wr_cyc = r_write;
                w_rd_cyc = !r_write;
                w_pready = r_write;
            end
            c_st_rd_wait: begin
                w_pready  = 1'b1;
                w_rd_done = 1'b1;
            end
            default: begin
                w_pready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture during the SETUP cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_addr  <= '0;
            r_write <= 1'b0;
        end else if (w_setup) begin
            r_addr  <= paddr;
            r_write <= pwrite;
        end
    end

    // ------------------------------------------------------------------
    // Address decode and write qualification
    // ------------------------------------------------------------------
    assign w_is_ctrl   = (r_addr == c_addr_ctrl);
    assign w_is_status = (r_addr == c_addr_status);
    assign w_is_result = (r_addr == c_addr_result);
    assign w_is_pix    = (r_addr >= c_addr_pix);

    assign w_any_strb  = |w_strb;
    // START and DONE both live in byte lane 0.
    assign w_start_bit = pwdata[c_ctrl_start_bit]  & w_strb[0];
    assign w_clr_bit   = pwdata[c_status_done_bit] & w_strb[0];

    // A write with no strobes touches nothing and is never an error.
    assign w_err = w_wr_cyc & w_any_strb &
                   (w_is_result |
                    (w_is_pix  & core_busy) |
                    (w_is_ctrl & w_start_bit & core_busy));

    assign w_start_req = w_wr_cyc & w_is_ctrl & w_start_bit & ~core_busy;
    assign w_clr_done  = w_wr_cyc & w_is_status & w_clr_bit;
    assign w_ram_be    = (w_wr_cyc & w_is_pix & ~core_busy) ? w_strb : '0;

    // Register read mux; CTRL and unused bits read as zero.
    always_comb begin
        w_reg_rdata_next = '0;
        if (w_is_status) begin
            w_reg_rdata_next[c_status_busy_bit] = core_busy;
            w_reg_rdata_next[c_status_done_bit] = r_done;
        end else if (w_is_result) begin
            w_reg_rdata_next = r_result;
        end
    end

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_done      <= 1'b0;
            r_result    <= '0;
            r_start     <= 1'b0;
            r_reg_rdata <= '0;
            r_rd_pix    <= 1'b0;
            r_core_zero <= 1'b1;
        end else begin
            r_start <= w_start_req;
            // A done pulse beats a simultaneous W1C so no completion is lost.
            if (core_done) begin
                r_done   <= 1'b1;
                r_result <= core_result;
            end else if (w_clr_done) begin
                r_done <= 1'b0;
            end
            // Register reads are sampled alongside the RAM read so both
            // kinds of read present data in the same cycle.
            if (w_rd_cyc) begin
                r_reg_rdata <= w_reg_rdata_next;
                r_rd_pix    <= w_is_pix;
            end
            // Core reads below the pixel base return zero; the flag is
            // aligned with the one-cycle RAM latency.
            r_core_zero <= (core_raddr < c_addr_pix);
        end
    end

    // ------------------------------------------------------------------
    // Pixel bank
    // ------------------------------------------------------------------
    pixel_ram_dp #(
        .WIDTH      (AMBA_WORD),
        .DEPTH_LOG2 (AMBA_ADDR_DEPTH)
    ) u_pixel_ram (
        .clk        (clock),
        .i_a_addr   (r_addr),
        .i_a_be     (w_ram_be),
        .i_a_wdata  (pwdata),
        .o_a_rdata  (w_ram_a_rdata),
        .i_b_addr   (core_raddr),
        .o_b_rdata  (w_ram_b_rdata)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pready     = w_pready;
    assign pslverr    = w_err;
    assign prdata     = w_rd_done ? (r_rd_pix ? w_ram_a_rdata : r_reg_rdata) : '0;
    assign start      = r_start;
    assign core_rdata = r_core_zero ? '0 : w_ram_b_rdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_pixel_regfile.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_apb_pixel_regfile
// Purpose : Self-checking bench for apb_pixel_regfile. Transfers push their
//           expected response into a queue; a monitor pops and compares on
//           every pready. Reference model is a word array plus DONE/RESULT.
//           Honours APB_PSTRB_EN for the byte-strobe cases.
// Revision: 1.0 - initial release
// ============================================================================
module tb_apb_pixel_regfile;

    localparam int AW = 24;
    localparam int AD = 12;
    localparam int NB = AW / 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [AD-1:0] paddr = '0;
    logic [AW-1:0] pwdata = '0;
    logic [NB-1:0] pstrb = '1;
    logic [AW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic          start;
    logic          core_busy = 1'b0;
    logic          core_done = 1'b0;
    logic [AW-1:0] core_result = '0;
    logic [AD-1:0] core_raddr = '0;
    logic [AW-1:0] core_rdata;

    apb_pixel_regfile #(
        .AMBA_WORD       (AW),
        .AMBA_ADDR_DEPTH (AD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
`ifdef APB_PSTRB_EN
        .pstrb       (pstrb),
`endif
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .start       (start),
        .core_busy   (core_busy),
        .core_done   (core_done),
        .core_result (core_result),
        .core_raddr  (core_raddr),
        .core_rdata  (core_rdata)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cnt = 0;
    int exp_starts = 0;

    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (start) start_cnt++;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [AW-1:0] mem [int];
    bit            m_done = 1'b0;
    logic [AW-1:0] m_result = '0;

    function automatic void model_apply(input bit wr, input int addr, input logic [AW-1:0] data,
                                        input logic [NB-1:0] strb, input bit busy, input bit dp,
                                        input logic [AW-1:0] dv, output bit err, output logic [AW-1:0] rd);
        err = 1'b0;
        rd  = '0;
        if (!wr) begin
            if (addr == 1)      rd = AW'({m_done, busy});
            else if (addr == 2) rd = m_result;
            else if (addr >= 3) rd = mem[addr];
        end else if (strb != '0) begin
            if (addr == 2) begin
                err = 1'b1;
            end else if (addr == 0) begin
                if (data[0] && strb[0]) begin
                    if (busy) err = 1'b1;
                    else      exp_starts++;
                end
            end else if (addr == 1) begin
                if (data[1] && strb[0]) m_done = 1'b0;
            end else if (busy) begin
                err = 1'b1;
            end else begin
                for (int b = 0; b < NB; b++)
                    if (strb[b]) mem[addr][8*b +: 8] = data[8*b +: 8];
            end
        end
        if (dp) begin
            m_done   = 1'b1;
            m_result = dv;
        end
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        bit            rd;
        logic [AW-1:0] data;
        bit            err;
        int            setup;
        int            addr;
    } exp_t;

    exp_t q[$];

    always @(negedge clock) begin
        exp_t e;
        if (reset && pready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pready: got pready=1, expected no response (t=%0t)", $time);
            end else begin
                e = q.pop_front();
                check($sformatf("pslverr@%0h", e.addr), 32'(pslverr), 32'(e.err));
                check($sformatf("latency@%0h", e.addr), 32'(cyc - e.setup), e.rd ? 32'd2 : 32'd1);
                if (e.rd) check($sformatf("prdata@%0h", e.addr), 32'(prdata), 32'(e.data));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks
    // ------------------------------------------------------------------
    task automatic idle();
        @(posedge clock); #1;
        psel = 1'b0;
        penable = 1'b0;
        core_done = 1'b0;
    endtask

    task automatic xfer(input bit wr, input int addr, input logic [AW-1:0] data,
                        input logic [NB-1:0] strb, input bit busy, input bit keep,
                        input bit dp, input logic [AW-1:0] dv);
        exp_t e;
        int   n;
        @(posedge clock); #1;
        core_done = 1'b0;
        core_busy = busy;
        psel = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = AD'(addr);
        pwdata = data;
        pstrb = strb;
        e.rd = !wr;
        e.setup = cyc;
        e.addr = addr;
        model_apply(wr, addr, data, strb, busy, dp, dv, e.err, e.data);
        q.push_back(e);
        @(posedge clock); #1;
        penable = 1'b1;
        if (dp) begin
            core_done = 1'b1;
            core_result = dv;
        end
        n = 0;
        forever begin
            @(negedge clock);
            if (pready) break;
            n++;
            if (n >= 8) begin
                tests++;
                fails++;
                $display("FAIL pready_timeout@%0h: got no pready, expected pready within 2 cycles", addr);
                break;
            end
        end
        if (!keep) idle();
    endtask

    task automatic wr(input int addr, input logic [AW-1:0] data, input bit busy);
        xfer(1'b1, addr, data, '1, busy, 1'b0, 1'b0, '0);
    endtask

    task automatic rd(input int addr);
        xfer(1'b0, addr, '0, '1, core_busy, 1'b0, 1'b0, '0);
    endtask

    task automatic done_pulse(input logic [AW-1:0] v);
        @(posedge clock); #1;
        core_done = 1'b1;
        core_result = v;
        m_done = 1'b1;
        m_result = v;
        @(posedge clock); #1;
        core_done = 1'b0;
    endtask

    task automatic core_check(input int addr);
        logic [AW-1:0] exp;
        @(posedge clock); #1;
        core_raddr = AD'(addr);
        exp = (addr < 3) ? '0 : mem[addr];
        @(posedge clock);
        @(negedge clock);
        check($sformatf("core_rdata@%0h", addr), 32'(core_rdata), 32'(exp));
    endtask

    task automatic check_starts(input string name);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check(name, 32'(start_cnt), 32'(exp_starts));
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [AW-1:0] old5;
        int            a;
        int            sel;
        bit            keep;
        bit            busy;
        bit            w;

        // Power-on reset
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        check("rst_prdata", 32'(prdata), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_core_rdata", 32'(core_rdata), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        rd(1);
        rd(2);

        // Fill the pixel addresses used later
        for (int i = 3; i < 35; i++) wr(i, AW'($urandom), 1'b0);
        for (int i = 4092; i < 4096; i++) wr(i, AW'($urandom), 1'b0);

        // Basic write / read / core port
        wr(5, 24'h123456, 1'b0);
        rd(5);
        core_check(5);
        core_check(2);
        core_check(4095);

        // Same-cycle APB write and core read of one address: old word first
        core_check(5);
        old5 = mem[5];
        xfer(1'b1, 5, 24'h0F0F0F, '1, 1'b0, 1'b1, 1'b0, '0);
        @(negedge clock);
        check("core_old_word", 32'(core_rdata), 32'(old5));
        @(negedge clock);
        check("core_new_word", 32'(core_rdata), 32'(mem[5]));
        idle();

        // Start pulse, busy write-protect
        wr(0, 24'h000001, 1'b0);
        check_starts("start_single");
        wr(0, 24'h000001, 1'b1);
        check_starts("start_blocked");
        wr(7, 24'hDEADBE, 1'b1);
        rd(7);
        wr(0, 24'hFFFFFE, 1'b0);
        check_starts("start_bit0_clear");
        core_busy = 1'b1;
        rd(1);
        core_busy = 1'b0;

        // DONE / RESULT
        done_pulse(24'h000002);
        rd(1);
        rd(2);
        wr(1, 24'h000002, 1'b0);
        rd(1);
        done_pulse(24'h000003);
        xfer(1'b1, 1, 24'h000002, '1, 1'b0, 1'b0, 1'b1, 24'h000007);
        rd(1);
        rd(2);

        // RESULT is read-only; back-to-back transfers
        wr(2, 24'h555555, 1'b0);
        rd(2);
        xfer(1'b1, 10, 24'hABCDEF, '1, 1'b0, 1'b1, 1'b0, '0);
        xfer(1'b0, 10, '0, '1, 1'b0, 1'b1, 1'b0, '0);
        xfer(1'b1, 11, 24'h13579B, '1, 1'b0, 1'b1, 1'b0, '0);
        xfer(1'b0, 11, '0, '1, 1'b0, 1'b0, 1'b0, '0);

`ifdef APB_PSTRB_EN
        wr(9, 24'hAABBCC, 1'b0);
        xfer(1'b1, 9, 24'h112233, 3'b010, 1'b0, 1'b0, 1'b0, '0);
        rd(9);
        xfer(1'b1, 9, 24'h445566, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        rd(9);
        xfer(1'b1, 0, 24'h000001, 3'b110, 1'b0, 1'b0, 1'b0, '0);
        check_starts("start_lane_masked");
`endif

        // Randomised traffic
        for (int n = 0; n < 120; n++) begin
            sel  = $urandom_range(0, 9);
            a    = (sel < 3) ? sel : (($urandom_range(0, 1) == 1) ? 3 + $urandom_range(0, 31)
                                                                 : 4092 + $urandom_range(0, 3));
            w    = $urandom_range(0, 1) == 1;
            busy = $urandom_range(0, 3) == 0;
            keep = $urandom_range(0, 2) == 0;
`ifdef APB_PSTRB_EN
            xfer(w, a, AW'($urandom), NB'($urandom), busy, keep, 1'b0, '0);
`else
            xfer(w, a, AW'($urandom), '1, busy, keep, 1'b0, '0);
`endif
            if ($urandom_range(0, 7) == 0) done_pulse(AW'($urandom));
            if ($urandom_range(0, 5) == 0) core_check(3 + $urandom_range(0, 31));
        end
        idle();
        core_busy = 1'b0;
        check_starts("start_random");

        // Reset in the second ACCESS cycle of a read aborts it
        done_pulse(24'h000009);
        @(posedge clock); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = AD'(1);
        @(posedge clock); #1;
        penable = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("abort_pready", 32'(pready), 32'd0);
        check("abort_prdata", 32'(prdata), 32'd0);
        check("abort_start", 32'(start), 32'd0);
        check("abort_core_rdata", 32'(core_rdata), 32'd0);
        m_done = 1'b0;
        m_result = '0;
        @(posedge clock); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        rd(1);
        rd(2);
        rd(5);
        check_starts("start_after_reset");

        repeat (4) @(posedge clock);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
